// File: rtl/iob_bit_packer.sv
// ---------------------------------------------------------------------------
// iob_bit_packer
//
// Purpose:
//   Repacks a stream of variable-width, MSB-aligned bit fields (0..DATA_W bits
//   each) into full DATA_W-bit words. The first bit received lands at the MSB
//   of the output word. Full words leave through a single valid/ready output
//   register.
//
// Optional feature:
//   IOB_BIT_PACKER_FLUSH_EN - when defined, adds the flush_i port. Holding
//   flush_i high blocks new fields and emits any partial word, zero-padded.
//   When undefined, residual bits stay in the accumulator until later fields
//   complete the word or until reset.
//
// Ports:
//   clk_i        in   1        clock, rising edge
//   rst_i        in   1        synchronous active-high reset
//   in_valid_i   in   1        field present
//   in_ready_o   out  1        field accepted on in_valid_i & in_ready_o
//   in_width_i   in   WIDTH_W  field width 0..DATA_W (larger values clamp)
//   in_data_i    in   DATA_W   field, MSB-aligned
//   flush_i      in   1        emit partial word (flush build only)
//   out_valid_o  out  1        out_data_o holds a word
//   out_ready_i  in   1        word consumed on out_valid_o & out_ready_i
//   out_data_o   out  DATA_W   packed word
//   level_o      out  WIDTH_W  bits held in the accumulator
//   idle_o       out  1        accumulator empty and no word pending
// ---------------------------------------------------------------------------
module iob_bit_packer #(
    parameter  int DATA_W  = 21,
    localparam int WIDTH_W = $clog2(DATA_W) + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH_W-1:0] in_width_i,
    input  logic [DATA_W-1:0]  in_data_i,
`ifdef IOB_BIT_PACKER_FLUSH_EN
    input  logic               flush_i,
`endif
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [DATA_W-1:0]  out_data_o,
    output logic [WIDTH_W-1:0] level_o,
    output logic               idle_o
);

    localparam logic [DATA_W-1:0]  ONES     = '1;
    localparam logic [WIDTH_W-1:0] WIDTH_DW = WIDTH_W'(DATA_W);
    localparam logic [WIDTH_W:0]   SUM_DW   = (WIDTH_W + 1)'(DATA_W);

    // Accumulator invariant: the top count_reg bits hold pending data and
    // every bit below them is zero, so new fields can simply be OR-ed in.
    logic [2*DATA_W-1:0] acc_reg,       acc_next;
    logic [WIDTH_W-1:0]  count_reg,     count_next;
    logic [DATA_W-1:0]   out_data_reg,  out_data_next;
    logic                out_valid_reg, out_valid_next;

    logic                slot_free;
    logic                accept;
    logic [WIDTH_W-1:0]  width_clamped;
    logic [DATA_W-1:0]   field_mask;
    logic [2*DATA_W-1:0] placed;
    logic [2*DATA_W-1:0] acc_merged;
    logic [WIDTH_W:0]    sum;

    assign slot_free = ~out_valid_reg | out_ready_i;

`ifdef IOB_BIT_PACKER_FLUSH_EN
    assign in_ready_o = slot_free & ~flush_i;
`else
    assign in_ready_o = slot_free;
`endif

    assign accept = in_valid_i & in_ready_o;

    always_comb begin
        width_clamped = (in_width_i > WIDTH_DW) ? WIDTH_DW : in_width_i;
        // Keep only the top width_clamped bits of the field. A shift by
        // DATA_W yields zero, so a full-width field keeps every bit.
        field_mask    = ~(ONES >> width_clamped);
        placed        = {in_data_i & field_mask, {DATA_W{1'b0}}} >> count_reg;
        acc_merged    = acc_reg | placed;
        sum           = {1'b0, count_reg} + {1'b0, width_clamped};

        acc_next       = acc_reg;
        count_next     = count_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg & ~out_ready_i;

        if (accept) begin
            if (sum >= SUM_DW) begin
                out_data_next  = acc_merged[2*DATA_W-1:DATA_W];
                acc_next       = acc_merged << DATA_W;
                count_next     = WIDTH_W'(sum - SUM_DW);
                out_valid_next = 1'b1;
            end else begin
                acc_next   = acc_merged;
                count_next = WIDTH_W'(sum);
            end
        end
`ifdef IOB_BIT_PACKER_FLUSH_EN
        else if (flush_i && (count_reg != '0) && slot_free) begin
            // Residual bits already sit at the top with zeros below; the
            // explicit mask keeps the padding guarantee local to this path.
            out_data_next  = acc_reg[2*DATA_W-1:DATA_W] & ~(ONES >> count_reg);
            acc_next       = '0;
            count_next     = '0;
            out_valid_next = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_reg       <= '0;
            count_reg     <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            acc_reg       <= acc_next;
            count_reg     <= count_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign out_valid_o = out_valid_reg;
    assign out_data_o  = out_data_reg;
    assign level_o     = count_reg;
    assign idle_o      = (count_reg == '0) & ~out_valid_reg;

endmodule

// File: tb/tb_iob_bit_packer.sv
module tb_iob_bit_packer;

    localparam int DATA_W  = 8;
    localparam int WIDTH_W = $clog2(DATA_W) + 1;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [WIDTH_W-1:0] in_width_i;
    logic [DATA_W-1:0]  in_data_i;
`ifdef IOB_BIT_PACKER_FLUSH_EN
    logic               flush_i;
`endif
    logic               out_valid_o;
    logic               out_ready_i;
    logic [DATA_W-1:0]  out_data_o;
    logic [WIDTH_W-1:0] level_o;
    logic               idle_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    iob_bit_packer #(.DATA_W(DATA_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_width_i  (in_width_i),
        .in_data_i   (in_data_i),
`ifdef IOB_BIT_PACKER_FLUSH_EN
        .flush_i     (flush_i),
`endif
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .level_o     (level_o),
        .idle_o      (idle_o)
    );

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [WIDTH_W-1:0] w, input logic [DATA_W-1:0] d);
        in_valid_i = 1'b1;
        in_width_i = w;
        in_data_i  = d;
        tick();
        in_valid_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        in_width_i  = '0;
        in_data_i   = '0;
        out_ready_i = 1'b1;
`ifdef IOB_BIT_PACKER_FLUSH_EN
        flush_i     = 1'b0;
`endif
        tick();
        tick();
        rst_i = 1'b0;

        // Reset state
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_out_data",  32'(out_data_o),  32'h00);
        check("rst_level",     32'(level_o),     32'd0);
        check("rst_idle",      32'(idle_o),      32'd1);
        check("rst_in_ready",  32'(in_ready_o),  32'd1);
        $display("reset: out_valid=%0d level=%0d idle=%0d", out_valid_o, level_o, idle_o);

        // Basic pack: 101 + 11001 -> 10111001
        send(4'd3, 8'hA0);
        check("basic_level3",  32'(level_o),     32'd3);
        check("basic_nvalid",  32'(out_valid_o), 32'd0);
        send(4'd5, 8'hC8);
        check("basic_valid",   32'(out_valid_o), 32'd1);
        check("basic_data",    32'(out_data_o),  32'hB9);
        check("basic_level0",  32'(level_o),     32'd0);
        $display("basic: word=%02h level=%0d", out_data_o, level_o);
        tick();
        check("basic_drained", 32'(out_valid_o), 32'd0);
        check("basic_hold",    32'(out_data_o),  32'hB9);

        // Wrap with remainder
        send(4'd6, 8'hFC);
        check("wrap_level6",   32'(level_o),     32'd6);
        send(4'd6, 8'h00);
        check("wrap_data1",    32'(out_data_o),  32'hFC);
        check("wrap_level4",   32'(level_o),     32'd4);
        check("wrap_valid1",   32'(out_valid_o), 32'd1);
        send(4'd4, 8'hF0);
        check("wrap_data2",    32'(out_data_o),  32'h0F);
        check("wrap_level0",   32'(level_o),     32'd0);
        check("wrap_valid2",   32'(out_valid_o), 32'd1);
        $display("wrap: word=%02h level=%0d", out_data_o, level_o);
        tick();

        // Zero-width field is a no-op; oversize width clamps to DATA_W
        send(4'd0, 8'hFF);
        check("w0_level",      32'(level_o),     32'd0);
        check("w0_nvalid",     32'(out_valid_o), 32'd0);
        send(4'd15, 8'hAB);
        check("clamp_data",    32'(out_data_o),  32'hAB);
        check("clamp_level",   32'(level_o),     32'd0);
        $display("clamp: word=%02h level=%0d", out_data_o, level_o);
        tick();

        // Backpressure
        send(4'd8, 8'h11);
        check("bp_w1",         32'(out_data_o),  32'h11);
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_width_i  = 4'd8;
        in_data_i   = 8'h22;
        #1;
        check("bp_ready_low",  32'(in_ready_o),  32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_stall_data",  32'(out_data_o),  32'h11);
            check("bp_stall_valid", 32'(out_valid_o), 32'd1);
            check("bp_stall_ready", 32'(in_ready_o),  32'd0);
        end
        out_ready_i = 1'b1;
        #1;
        check("bp_ready_high", 32'(in_ready_o),  32'd1);
        tick();
        check("bp_w2",         32'(out_data_o),  32'h22);
        in_data_i = 8'h33;
        tick();
        check("bp_w3",         32'(out_data_o),  32'h33);
        in_data_i = 8'h44;
        tick();
        check("bp_w4",         32'(out_data_o),  32'h44);
        check("bp_w4_valid",   32'(out_valid_o), 32'd1);
        in_valid_i = 1'b0;
        tick();
        check("bp_drained",    32'(out_valid_o), 32'd0);
        $display("backpressure: last word=%02h level=%0d", out_data_o, level_o);

`ifdef IOB_BIT_PACKER_FLUSH_EN
        // Flush a partial word
        send(4'd3, 8'hA0);
        check("fl_level3",     32'(level_o),     32'd3);
        flush_i = 1'b1;
        #1;
        check("fl_ready_low",  32'(in_ready_o),  32'd0);
        tick();
        check("fl_data",       32'(out_data_o),  32'hA0);
        check("fl_valid",      32'(out_valid_o), 32'd1);
        check("fl_level0",     32'(level_o),     32'd0);
        flush_i = 1'b0;
        tick();
        check("fl_idle",       32'(idle_o),      32'd1);
        $display("flush: word=%02h idle=%0d", out_data_o, idle_o);
`endif

        // Reset mid-operation: 11111 + 01011010 -> word FA, 5 bits left
        send(4'd5, 8'hF8);
        out_ready_i = 1'b0;
        send(4'd8, 8'h5A);
        check("mr_data",       32'(out_data_o),  32'hFA);
        check("mr_level5",     32'(level_o),     32'd5);
        check("mr_valid",      32'(out_valid_o), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mr_rst_valid",  32'(out_valid_o), 32'd0);
        check("mr_rst_level",  32'(level_o),     32'd0);
        check("mr_rst_data",   32'(out_data_o),  32'h00);
        check("mr_rst_idle",   32'(idle_o),      32'd1);
        out_ready_i = 1'b1;
        tick();
        tick();
        check("mr_no_emit",    32'(out_valid_o), 32'd0);
        $display("reset-mid: out_valid=%0d level=%0d", out_valid_o, level_o);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
